mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared single-port Memory (combinational read, synchronous write, tri-state data bus).
- Requester 0 is the game-logic engine; requester 1 is the display scanner.
- The block serialises their accesses, owns mem_re/mem_we/mem_addr, drives the data bus only during writes, and returns registered read data with a one-cycle ack.

Parameters:
- DW, 16, data width of the memory word and bus.
- W, 256, memory depth in words.
- AW, $clog2(W), address width.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- preset_L  input  1  reset, asynchronous, active-low.
- req  input  2  req[i] high = requester i wants one access; held until ack[i].
- we_in  input  2  we_in[i] 1 = write, 0 = read; valid while req[i].
- addr0, addr1  input  AW  access address per requester; valid while req[i].
- wdata0, wdata1  input  DW  write data per requester; valid while req[i].
- ack  output  2  one-cycle pulse, one-hot, access of requester i complete.
- rdata0, rdata1  output  DW  registered read data per requester.
- gnt  output  2  one-hot owner during ACCESS and DONE; 0 in IDLE.
- busy  output  1  high in ACCESS and DONE.
- mem_re  output  1  memory read enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_data  inout  DW  tri-state memory data bus.

Behaviour:
- Reset (preset_L low, asynchronous):
  - state=IDLE, last=1, all internal latches 0.
  - ack=0, gnt=0, busy=0, mem_re=0, mem_we=0, mem_addr=0, rdata0=rdata1=0, mem_data released (z).
- Reset mid-access aborts immediately. A write in ACCESS is dropped because mem_we falls asynchronously. No ack is issued.
- FSM states: IDLE, ACCESS, DONE. All outputs are Moore-decoded from registered state and latches. No combinational path from req to mem_* or ack.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise pick a winner w, latch addr_w/wdata_w/we_in[w] and w, go to ACCESS.
- Pick rule:
  - Single request wins.
  - Both requesting: winner = index != last (round-robin). After reset, requester 0 wins the first tie.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr; gnt[w]=1.
  - Write: mem_we=1, mem_re=0, bus driven with latched wdata. Memory commits at the closing edge.
  - Read: mem_re=1, mem_we=0, bus released. At the closing edge, mem_data is captured into rdata_w.
  - Next state: DONE.
- DONE (exactly 1 cycle):
  - ack[w]=1, gnt[w]=1.
  - mem_re=mem_we=0, bus released. This is the mandatory turnaround cycle; no contention between a write drive and the next read.
  - rdata_w is valid now and holds until the next completed read by the same requester. Writes do not alter rdata.
  - At the closing edge: last=w, state=IDLE.
- Latency: req sampled at edge k -> ACCESS in cycle k+1 -> ack in cycle k+2. Peak throughput is one access per 3 cycles.
- Requester rule:
  - Drop req[i] in the cycle after ack[i].
  - req[i] still high in IDLE is treated as a new request (same address is accessed again).
  - Changes to addr/wdata/we_in after latching have no effect on the access in flight.
- Requests arriving while busy wait. A waiting requester is guaranteed service within 2 accesses (starvation-free).
- mem_addr holds its last value in IDLE/DONE; it is only meaningful while mem_re or mem_we is high.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {IDLE, ACCESS, DONE}.
  - Constants REQ_GAME=0, REQ_DISP=1.
- Sub-module rr_pick_2: combinational; inputs req[1:0], last; outputs winner, valid.
- Tri-state drive uses the existing BusDriver library module with en = (state==ACCESS && latched write).

Test Plan:
- Reset, then req=01, we_in=01, addr0=8'h10, wdata0=16'hBEEF:
  - mem_we high exactly in cycle k+1 with mem_data=16'hBEEF.
  - ack=01 in cycle k+2.
  - Read back of 8'h10 by requester 1 returns rdata1=16'hBEEF.
- req=11 held continuously after reset, both reads:
  - gnt sequence 01,10,01,10; acks alternate every 3 cycles.
  - Neither requester is granted twice in a row.
- Requester 0 writes 16'h1234 to 8'h20, then requester 1 immediately reads 8'h20:
  - rdata1=16'h1234.
  - Bus is z in the DONE cycle between the two accesses (no X on mem_data).
- Assert preset_L low during ACCESS of a write of 16'hAAAA to 8'h30 that previously held 16'h5555:
  - mem_we drops immediately, no ack, state=IDLE.
  - 8'h30 reads back 16'h5555.
- Requester 1 reads 8'h40 (=16'h0F0F); requester 1 then writes 8'h41:
  - rdata1 stays 16'h0F0F after the write's ack.
  - rdata0 is unchanged throughout.
- Change addr0 from 8'h50 to 8'h51 during ACCESS:
  - Access completes to 8'h50.
  - Holding req0 past ack starts a new access 1 cycle later (IDLE sample) to 8'h51.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

  localparam int   NREQ     = 2;
  localparam logic REQ_GAME = 1'b0;
  localparam logic REQ_DISP = 1'b1;

  function automatic logic [NREQ-1:0] onehot2(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake bundle: two requesters sharing one arbiter.
interface mem_port_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic [1:0]    req;
  logic [1:0]    we_in;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    ack;
  logic [1:0]    gnt;
  logic          busy;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  modport master (
    output req, we_in, addr0, addr1, wdata0, wdata1,
    input  ack, gnt, busy, rdata0, rdata1
  );

  modport slave (
    input  req, we_in, addr0, addr1, wdata0, wdata1,
    output ack, gnt, busy, rdata0, rdata1
  );
endinterface

// File: rtl/mem_port_arbiter_bus_driver.sv
// Library tri-state driver: drives the shared bus only while enabled.
module BusDriver #(
  parameter int W = 16
) (
  input  logic         en,
  input  logic [W-1:0] din,
  inout  wire  [W-1:0] bus
);
  assign bus = en ? din : {W{1'bz}};
endmodule

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-way round-robin pick: on a tie the requester that did not go last wins.
module rr_pick_2
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic            i_last,
  output logic            o_winner,
  output logic            o_valid
);
  always_comb begin
    o_valid  = |i_req;
    o_winner = REQ_GAME;
    if (&i_req)
      o_winner = ~i_last;
    else if (i_req[REQ_DISP])
      o_winner = REQ_DISP;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises game-engine and display-scanner accesses onto the single-port
// memory: IDLE -> ACCESS (one memory cycle) -> DONE (ack + bus turnaround).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW = 16,
  parameter int W  = 256,
  parameter int AW = $clog2(W)
) (
  input  logic              clock,
  input  logic              preset_L,
  mem_port_arbiter_if.slave rq,
  output logic              mem_re,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  inout  wire  [DW-1:0]     mem_data
);
  arb_state_t                r_state;
  logic                      r_last;
  logic                      r_win;
  logic                      r_we;
  logic [AW-1:0]             r_addr;
  logic [DW-1:0]             r_wdata;
  logic [NREQ-1:0][DW-1:0]   r_rdata;
  logic [NREQ-1:0]           r_ack;
  logic [NREQ-1:0]           r_gnt;
  logic                      r_busy;
  logic                      r_re;
  logic                      r_wen;
  logic                      w_win;
  logic                      w_vld;

  rr_pick_2 u_pick (
    .i_req    (rq.req),
    .i_last   (r_last),
    .o_winner (w_win),
    .o_valid  (w_vld)
  );

  // Outputs are all registered, so an async reset clears mem_we mid-write.
  always_ff @(posedge clock or negedge preset_L) begin
    if (!preset_L) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_re    <= 1'b0;
      r_wen   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_vld) begin
            r_win   <= w_win;
            r_we    <= rq.we_in[w_win];
            r_addr  <= w_win ? rq.addr1 : rq.addr0;
            r_wdata <= w_win ? rq.wdata1 : rq.wdata0;
            r_gnt   <= onehot2(w_win);
            r_busy  <= 1'b1;
            r_re    <= ~rq.we_in[w_win];
            r_wen   <= rq.we_in[w_win];
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!r_we)
            r_rdata[r_win] <= mem_data;
          r_re    <= 1'b0;
          r_wen   <= 1'b0;
          r_ack   <= onehot2(r_win);
          r_state <= DONE;
        end
        DONE: begin
          r_last  <= r_win;
          r_ack   <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus is driven only during a write ACCESS; DONE is the turnaround gap.
  BusDriver #(.W(DW)) u_drv (
    .en  (r_wen),
    .din (r_wdata),
    .bus (mem_data)
  );

  assign mem_re    = r_re;
  assign mem_we    = r_wen;
  assign mem_addr  = r_addr;
  assign rq.ack    = r_ack;
  assign rq.gnt    = r_gnt;
  assign rq.busy   = r_busy;
  assign rq.rdata0 = r_rdata[0];
  assign rq.rdata1 = r_rdata[1];
endmodule
